// File: rtl/flag_unit.sv
// flag_unit: producer of the NZCV condition flags.
// Derives N/Z/C/V from execute-stage ALU results, holds the live flag
// register, and keeps a small shadow stack for exception entry/return.
module flag_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       InValid,
  input  logic                       Stall,
  input  logic                       CondEx,
  input  logic [1:0]                 FlagW,
  input  logic                       ArithOp,
  input  logic                       SubOp,
  input  logic [WIDTH-1:0]           ALUResult,
  input  logic                       SrcAMsb,
  input  logic                       SrcBMsb,
  input  logic                       AdderCout,
  input  logic                       ShCarry,
  input  logic                       SaveFlags,
  input  logic                       RestoreFlags,
  input  logic                       ErrClr,
  output logic [3:0]                 Flags,
  output logic [$clog2(DEPTH+1)-1:0] StackCount,
  output logic                       StackFull,
  output logic                       StackEmpty,
  output logic                       OvfErr,
  output logic                       UnfErr
);

  localparam int CW = $clog2(DEPTH+1);

  logic [3:0]    flags;
  logic [3:0]    stack_mem [DEPTH];
  logic [CW-1:0] count;
  logic          ovf_err;
  logic          unf_err;

  logic          we;
  logic          n_n, n_z, n_c, n_v;
  logic [3:0]    written;
  logic [3:0]    top;
  logic          full;
  logic          empty;

  logic [3:0]    flags_nxt;
  logic [CW-1:0] count_nxt;
  logic          push_en;
  logic [CW-1:0] wr_idx;
  logic          ovf_set;
  logic          unf_set;
  logic          err_clr;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign we      = InValid & CondEx & ~Stall;
  assign err_clr = ErrClr & ~Stall;

  // Candidate flags from the ALU result; V is only meaningful for add/sub.
  always_comb begin
    n_n = ALUResult[WIDTH-1];
    n_z = (ALUResult == '0);
    n_c = ArithOp ? AdderCout : ShCarry;
    n_v = ArithOp ? (~(SrcAMsb ^ SrcBMsb ^ SubOp) & (SrcAMsb ^ ALUResult[WIDTH-1]))
                  : flags[0];
    written = flags;
    if (we) begin
      if (FlagW[1]) written[3:2] = {n_n, n_z};
      if (FlagW[0]) written[1:0] = {n_c, n_v};
    end
  end

  // Top-of-stack read by compare so the count never indexes past the array.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count == CW'(i + 1)) top = stack_mem[i];
    end
  end

  // Resolve push/pop/exchange priority against the normal flag write.
  always_comb begin
    flags_nxt = flags;
    count_nxt = count;
    push_en   = 1'b0;
    wr_idx    = count;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (!Stall) begin
      if (SaveFlags && RestoreFlags) begin
        if (!empty) begin
          flags_nxt = top;
          push_en   = 1'b1;
          wr_idx    = count - CW'(1);
        end else begin
          flags_nxt = written;
          push_en   = 1'b1;
          count_nxt = count + CW'(1);
          unf_set   = 1'b1;
        end
      end else if (SaveFlags) begin
        flags_nxt = written;
        if (!full) begin
          push_en   = 1'b1;
          count_nxt = count + CW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end else if (RestoreFlags) begin
        if (!empty) begin
          flags_nxt = top;
          count_nxt = count - CW'(1);
        end else begin
          flags_nxt = written;
          unf_set   = 1'b1;
        end
      end else begin
        flags_nxt = written;
      end
    end
  end

  // Live flags, stack storage and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags   <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_mem[i] <= '0;
    end else begin
      flags   <= flags_nxt;
      count   <= count_nxt;
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
      unf_err <= unf_set | (unf_err & ~err_clr);
      for (int i = 0; i < DEPTH; i++) begin
        if (push_en && wr_idx == CW'(i)) stack_mem[i] <= flags;
      end
    end
  end

  assign Flags      = flags;
  assign StackCount = count;
  assign StackFull  = full;
  assign StackEmpty = empty;
  assign OvfErr     = ovf_err;
  assign UnfErr     = unf_err;

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer side of the NZCV condition-flag interface.
- Derives N/Z/C/V from execute-stage ALU results and holds them in the architectural flag register. That register is the Flags bus consumed by the condition checker.
- Writes are gated by the instruction's CondEx and a per-group write enable.
- A small shadow stack saves and restores flags across exception entry and return.

Parameters:
- WIDTH, 32, ALU datapath width in bits.
- DEPTH, 4, shadow flag stack entries; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- InValid  in  1  execute-stage instruction valid.
- Stall  in  1  execute-stage stall; suppresses all updates except reset.
- CondEx  in  1  condition passed for the current instruction.
- FlagW  in  2  [1] writes N,Z; [0] writes C,V.
- ArithOp  in  1  1 = add/sub (C,V from adder), 0 = logical (C from shifter, V kept).
- SubOp  in  1  1 = subtract; valid when ArithOp=1.
- ALUResult  in  WIDTH  ALU result.
- SrcAMsb  in  1  MSB of operand A.
- SrcBMsb  in  1  MSB of operand B before inversion.
- AdderCout  in  1  adder carry-out.
- ShCarry  in  1  shifter carry-out.
- SaveFlags  in  1  push live flags (exception entry).
- RestoreFlags  in  1  pop into live flags (exception return).
- ErrClr  in  1  clears sticky error bits.
- Flags  out  4  {N,Z,C,V} live register.
- StackCount  out  $clog2(DEPTH+1)  occupied entries.
- StackFull  out  1  StackCount==DEPTH.
- StackEmpty  out  1  StackCount==0.
- OvfErr  out  1  sticky: push while full.
- UnfErr  out  1  sticky: pop while empty.

Behaviour:
- Reset (async, rst_n=0): Flags=4'b0000, StackCount=0, all stack entries 0, OvfErr=0, UnfErr=0. StackEmpty=1, StackFull=0.
- Next-flag computation (combinational):
  - nN = ALUResult[WIDTH-1]
  - nZ = (ALUResult==0)
  - nC = ArithOp ? AdderCout : ShCarry
  - nV = ArithOp ? (~(SrcAMsb^SrcBMsb^SubOp) & (SrcAMsb^ALUResult[WIDTH-1])) : Flags.V
- Write strobe: we = InValid & CondEx & ~Stall.
  - On a rising edge with we=1: FlagW[1] loads N,Z; FlagW[0] loads C,V.
  - Unwritten groups hold their value. Latency is 1 cycle; the new Flags are visible the cycle after the write.
- Stack operations act only when ~Stall. Stall=1 ignores Save/Restore/ErrClr for that cycle.
  - Push (Save only): if not full, stack[count] ← Flags as of the current cycle (pre-write value), count+1. Any concurrent we-write still updates live Flags. If full: no push, OvfErr←1.
  - Pop (Restore only): if not empty, Flags ← stack[count-1], count-1. Pop overrides any concurrent we-write to all four bits. If empty: Flags follow the normal we rule, UnfErr←1.
  - Save & Restore together, non-empty: exchange. stack[count-1] ← current Flags, Flags ← old stack[count-1], count unchanged, we-write discarded.
  - Save & Restore together, empty: push executes as a normal push, UnfErr←1.
- ErrClr clears OvfErr/UnfErr. A new error set in the same cycle wins (bit stays 1).
- rst_n asserted mid-operation clears everything immediately, regardless of clk. Deassertion is synchronous to clk, supplied by the reset tree.
- Flags is a pure register output with no combinational path from inputs.

Test Plan:
- Reset, then ALUResult=0, ArithOp=1, SubOp=1, A=B=5 (Cout=1), FlagW=11, CondEx=1 -> Flags=0110 next cycle.
- Add 0x7FFFFFFF+1 (SrcAMsb=0, SrcBMsb=0, Result MSB=1, Cout=0), FlagW=11 -> Flags=1001. Repeat with FlagW=10 and ALUResult=0 -> Flags=0101 (C,V held).
- CondEx=0 or Stall=1 with FlagW=11 and nonzero result -> Flags unchanged for that cycle.
- Set Flags=1010, Save, then write 0100, then Restore -> Flags=1010, StackCount returns 1→0, StackEmpty=1.
- DEPTH=4: five Saves -> StackCount=4, StackFull=1, OvfErr=1. Restore on empty stack -> UnfErr=1, Flags unchanged. ErrClr -> both 0.
- Flags=0001, one entry 1100: Save+Restore together with we=1 -> Flags=1100, top entry=0001, count=1. Assert rst_n=0 mid-sequence -> all outputs at reset values before the next edge.
